// File: rtl/random_word_buffer.sv
// random_word_buffer
// Decouples a free-running random word generator from a consumer.
// After reset the first Warmup generator words are thrown away, then
// nonzero words are collected into a show-ahead FIFO. Zero words are
// consumed from the generator but never stored.
module random_word_buffer #(
    parameter int Width  = 32,
    parameter int Depth  = 8,
    parameter int Warmup = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Width-1:0]           rnd,
    output logic                       rng_ce,
    input  logic                       flush,
    output logic [Width-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(Depth+1)-1:0] level,
    output logic                       full,
    output logic                       warm
);

    // Pointer, level and warmup-counter widths. A zero Warmup still
    // needs a one-bit counter so the declarations stay legal.
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int LW = $clog2(Depth + 1);
    localparam int CW = (Warmup > 0) ? $clog2(Warmup + 1) : 1;

    localparam logic [CW-1:0] WARM_LAST = (Warmup > 0) ? CW'(Warmup - 1) : {CW{1'b0}};
    localparam logic [CW-1:0] WARM_SAT  = CW'(Warmup);
    localparam logic [LW-1:0] LVL_MAX   = LW'(Depth);
    localparam logic [PW-1:0] PTR_LAST  = PW'(Depth - 1);

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_e;

    // With no warmup requested the buffer starts collecting immediately.
    localparam state_e RESET_STATE = (Warmup == 0) ? ST_RUN : ST_WARMUP;

    // Advance a FIFO pointer, wrapping at Depth (Depth need not be 2^n).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PTR_LAST) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    // Registered state
    state_e           state_q,    state_d;
    logic [CW-1:0]    warm_cnt_q, warm_cnt_d;
    logic [PW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0]    level_q,    level_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic [Width-1:0] mem_q [Depth];

    // Handshake terms
    logic in_run_s;
    logic pop_s;
    logic take_s;
    logic push_s;

    // Externally visible status. Everything that could start a transfer
    // is forced low while rst is high, even if the state is still RUN.
    assign in_run_s  = !rst && (state_q == ST_RUN);
    assign out_valid = !rst && (level_q != {LW{1'b0}});
    assign full      = !rst && (level_q == LVL_MAX);
    assign warm      = in_run_s;
    assign level     = level_q;
    assign out_data  = out_data_q;

    // Pop, take and push decisions for the current cycle. A flush
    // blocks the take; the pop it would allow is discarded later by
    // the flush branch of the next-state logic.
    always_comb begin
        pop_s  = out_valid && out_ready;
        take_s = in_run_s && !flush && ((level_q < LVL_MAX) || pop_s);
        push_s = take_s && (rnd != {Width{1'b0}});
    end

    // Generator advance: always during warmup, otherwise follows take.
    always_comb begin
        if (rst) begin
            rng_ce = 1'b0;
        end else if (state_q == ST_WARMUP) begin
            rng_ce = 1'b1;
        end else begin
            rng_ce = take_s;
        end
    end

    // Next-state logic for the FSM, warmup counter, pointers, level and
    // the show-ahead output register.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        out_data_d = out_data_q;

        case (state_q)
            ST_WARMUP: begin
                // Saturating count of discarded words.
                if (warm_cnt_q != WARM_SAT) begin
                    warm_cnt_d = warm_cnt_q + CW'(1);
                end else begin
                    warm_cnt_d = warm_cnt_q;
                end
                // Leave on the edge that closes the Warmup-th cycle.
                if (warm_cnt_q >= WARM_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WARMUP;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                if (flush) begin
                    // Drop everything; out_data keeps its stale value.
                    wr_ptr_d = {PW{1'b0}};
                    rd_ptr_d = {PW{1'b0}};
                    level_d  = {LW{1'b0}};
                end else begin
                    if (pop_s) begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end else begin
                        rd_ptr_d = rd_ptr_q;
                    end
                    if (push_s) begin
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                    case ({push_s, pop_s})
                        2'b10:   level_d = level_q + LW'(1);
                        2'b01:   level_d = level_q - LW'(1);
                        default: level_d = level_q;
                    endcase
                    // Preload the next head. When the new head is the
                    // slot being written this edge, bypass the array.
                    if (level_d != {LW{1'b0}}) begin
                        if (push_s && (wr_ptr_q == rd_ptr_d)) begin
                            out_data_d = rnd;
                        end else begin
                            out_data_d = mem_q[rd_ptr_d];
                        end
                    end else begin
                        out_data_d = out_data_q;
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            warm_cnt_q <= {CW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            level_q    <= {LW{1'b0}};
            out_data_q <= {Width{1'b0}};
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage array; only ever read at occupied slots, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rnd;
        end
    end

endmodule

// File: tb/tb_random_word_buffer.sv
// Directed bench for random_word_buffer (Width 8, Depth 4, Warmup 3),
// with a second instance built with Warmup 0.
module tb_random_word_buffer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rnd;
    logic       rng_ce;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       full;
    logic       warm;

    logic [7:0] rnd1;
    logic       rng_ce1;
    logic       flush1;
    logic [7:0] out_data1;
    logic       out_valid1;
    logic       out_ready1;
    logic [2:0] level1;
    logic       full1;
    logic       warm1;

    int n_vec = 0;
    int n_err = 0;

    random_word_buffer #(.Width(8), .Depth(4), .Warmup(3)) dut (
        .clk(clk), .rst(rst), .rnd(rnd), .rng_ce(rng_ce), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .full(full), .warm(warm)
    );

    random_word_buffer #(.Width(8), .Depth(4), .Warmup(0)) dut0 (
        .clk(clk), .rst(rst), .rnd(rnd1), .rng_ce(rng_ce1), .flush(flush1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .level(level1), .full(full1), .warm(warm1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic look();
        #2;
    endtask

    initial begin
        logic [7:0] drain_exp [5];
        drain_exp[0] = 8'd1; drain_exp[1] = 8'd2; drain_exp[2] = 8'd3;
        drain_exp[3] = 8'd4; drain_exp[4] = 8'd7;

        // ---------------- reset and warmup ----------------
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; rnd = 8'hA5;
        rnd1 = 8'h3C; flush1 = 1'b0; out_ready1 = 1'b0;
        step(); step();
        look();
        chk("rst_rng_ce",   rng_ce,    1'b0);
        chk("rst_warm",     warm,      1'b0);
        chk("rst_valid",    out_valid, 1'b0);
        chk("rst_full",     full,      1'b0);
        chk("rst_data",     out_data,  8'h00);
        chk("rst_level",    level,     3'd0);
        chk("rst_w0_ce",    rng_ce1,   1'b0);
        chk("rst_w0_warm",  warm1,     1'b0);
        step(); rst = 1'b0;                       // cycle 1
        look();
        chk("c1_rng_ce",  rng_ce,    1'b1);
        chk("c1_warm",    warm,      1'b0);
        chk("c1_valid",   out_valid, 1'b0);
        chk("w0_c1_warm", warm1,     1'b1);
        chk("w0_c1_ce",   rng_ce1,   1'b1);
        chk("w0_c1_lvl",  level1,    3'd0);
        step(); flush = 1'b1;                     // cycle 2, flush ignored
        look();
        chk("c2_rng_ce",  rng_ce,    1'b1);
        chk("c2_warm",    warm,      1'b0);
        chk("w0_c2_vld",  out_valid1, 1'b1);
        chk("w0_c2_data", out_data1, 8'h3C);
        chk("w0_c2_lvl",  level1,    3'd1);
        step(); flush = 1'b0;                     // cycle 3
        look();
        chk("c3_rng_ce",  rng_ce,    1'b1);
        chk("c3_warm",    warm,      1'b0);
        chk("c3_valid",   out_valid, 1'b0);
        step();                                   // cycle 4
        look();
        chk("c4_warm",    warm,      1'b1);
        chk("c4_rng_ce",  rng_ce,    1'b1);
        chk("c4_valid",   out_valid, 1'b0);
        step();                                   // cycle 5
        look();
        chk("c5_valid",   out_valid, 1'b1);
        chk("c5_data",    out_data,  8'hA5);
        chk("c5_level",   level,     3'd1);
        chk("w0_c5_full", full1,     1'b1);
        chk("w0_c5_lvl",  level1,    3'd4);
        chk("w0_c5_ce",   rng_ce1,   1'b0);

        // ---------------- fill and drain ----------------
        rst = 1'b1; rnd = 8'hA5; out_ready = 1'b0;
        step(); rst = 1'b0;                       // cycle 1
        step(); step();                           // cycle 3
        step(); rnd = 8'd1;                       // cycle 4
        look();
        chk("fill_c4_ce", rng_ce, 1'b1);
        for (int k = 2; k <= 4; k++) begin        // cycles 5..7
            step(); rnd = 8'(k);
            look();
            chk("fill_ce", rng_ce, 1'b1);
        end
        for (int k = 5; k <= 6; k++) begin        // cycles 8..9
            step(); rnd = 8'(k);
            look();
            chk("fill_full",  full,   1'b1);
            chk("fill_level", level,  3'd4);
            chk("fill_ce",    rng_ce, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin         // cycles 10..14
            step(); rnd = 8'd7; out_ready = 1'b1;
            look();
            chk("drain_data",  out_data, drain_exp[i]);
            chk("drain_level", level,    3'd4);
            chk("drain_ce",    rng_ce,   1'b1);
        end

        // ---------------- flush from full, then zero filter ----------------
        step(); flush = 1'b1; out_ready = 1'b1;   // cycle 15
        look();
        chk("fl4_ce", rng_ce, 1'b0);
        step(); flush = 1'b0; out_ready = 1'b0; rnd = 8'h00;   // cycle 16
        look();
        chk("fl4_level", level,     3'd0);
        chk("fl4_valid", out_valid, 1'b0);
        chk("fl4_hold",  out_data,  8'h07);
        chk("z0_ce",     rng_ce,    1'b1);
        step(); rnd = 8'h11; look(); chk("z1_ce", rng_ce, 1'b1);
        step(); rnd = 8'h00; look(); chk("z2_ce", rng_ce, 1'b1);
        step(); rnd = 8'h22; look(); chk("z3_ce", rng_ce, 1'b1);
        step(); rnd = 8'h00;                      // cycle 20
        look();
        chk("z_level", level,    3'd2);
        chk("z_data",  out_data, 8'h11);
        step(); out_ready = 1'b1;                 // cycle 21
        look();
        chk("z_hold", out_data, 8'h11);
        chk("z_lvl2", level,    3'd2);
        step(); out_ready = 1'b0; rnd = 8'h33;    // cycle 22
        look();
        chk("z_pop_data", out_data, 8'h22);
        chk("z_pop_lvl",  level,    3'd1);

        // ---------------- flush at level 3 ----------------
        step(); rnd = 8'h44;                      // cycle 23
        look();
        chk("f_lvl2", level, 3'd2);
        step(); rnd = 8'h55; flush = 1'b1; out_ready = 1'b1;   // cycle 24
        look();
        chk("f_lvl3", level,  3'd3);
        chk("f_ce",   rng_ce, 1'b0);
        step(); flush = 1'b0; out_ready = 1'b0; rnd = 8'h66;   // cycle 25
        look();
        chk("f_level", level,     3'd0);
        chk("f_valid", out_valid, 1'b0);
        chk("f_warm",  warm,      1'b1);
        chk("f_hold",  out_data,  8'h22);
        chk("f_ce2",   rng_ce,    1'b1);
        step(); rnd = 8'h77;                      // cycle 26
        look();
        chk("f_resume_vld",  out_valid, 1'b1);
        chk("f_resume_data", out_data,  8'h66);
        chk("f_resume_lvl",  level,     3'd1);

        // ---------------- reset mid-run ----------------
        step(); rnd = 8'h88; rst = 1'b1;          // cycle 27
        look();
        chk("mr_pre_lvl", level,     3'd2);
        chk("mr_rst_ce",  rng_ce,    1'b0);
        chk("mr_rst_wrm", warm,      1'b0);
        chk("mr_rst_vld", out_valid, 1'b0);
        chk("mr_rst_ful", full,      1'b0);
        step(); rst = 1'b0;                       // new cycle 1
        look();
        chk("mr_level", level,     3'd0);
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_warm",  warm,      1'b0);
        chk("mr_ce",    rng_ce,    1'b1);
        for (int i = 0; i < 2; i++) begin         // new cycles 2..3
            step();
            look();
            chk("mr_disc_warm", warm,  1'b0);
            chk("mr_disc_lvl",  level, 3'd0);
        end
        step(); rnd = 8'h99;                      // new cycle 4
        look();
        chk("mr_run_warm", warm,   1'b1);
        chk("mr_run_ce",   rng_ce, 1'b1);
        step();                                   // new cycle 5
        look();
        chk("mr_first_vld",  out_valid, 1'b1);
        chk("mr_first_data", out_data,  8'h99);
        chk("mr_first_lvl",  level,     3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
